gray_to_binary: RTL and testbench
=================================

Name: gray_to_binary

Overview:
- Converts a WIDTH-bit reflected Gray code word to its natural binary equivalent.
- The result is registered, with a one-cycle valid pipeline.
- Used wherever Gray-coded values (counter pointers, encoder positions) must be turned back into arithmetic binary.
- Single clock domain. Has no knowledge of where its input came from.

Parameters:
- WIDTH, 4, bit width of the Gray input and the binary output; legal range 1 to 64.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset; release is synchronous to clk.
- gray_in  input  WIDTH  Gray-coded word to convert; sampled only when gray_valid=1.
- gray_valid  input  1  qualifies gray_in for the current cycle.
- binary_out  output  WIDTH  registered binary result.
- binary_valid  output  1  high for exactly one cycle per accepted input, aligned with binary_out.

Behaviour:
- Conversion function (combinational, applied to gray_in):
  - b[WIDTH-1] = g[WIDTH-1].
  - b[i] = b[i+1] XOR g[i], for i = WIDTH-2 down to 0.
  - Equivalently, b[i] is the XOR of all g[j] with j >= i.
  - Full width is preserved, with no truncation or overflow.
- Latency:
  - Exactly 1 clock.
  - If gray_valid=1 at rising edge N, then at edge N:
    - binary_out takes the conversion of gray_in.
    - binary_valid = 1.
  - Both are visible in the cycle after edge N.
- Hold:
  - At an edge with gray_valid=0, binary_out keeps its previous value.
  - binary_valid goes to 0.
- Back-to-back:
  - gray_valid may stay high every cycle; throughput is one word per clock.
  - No backpressure: there is no ready signal, and every valid input is accepted.
- Reset:
  - While rst_n=0: binary_out=0 and binary_valid=0 immediately, without waiting for a clock edge.
  - Reset asserted mid-stream discards the in-flight result.
  - The first rising edge with rst_n=1 samples normally.
- gray_in is don't-care when gray_valid=0. X on gray_in with gray_valid=0 must not propagate to binary_out.
- WIDTH=1: binary_out equals gray_in, with the same 1-cycle latency.
- No other state, and no internal state machine beyond the output registers.
- Implementation:
  - Converter written as a generic loop over WIDTH.
  - Output flops use asynchronous reset on rst_n.

Test Plan:
- Reset: assert rst_n=0 while binary_out holds a nonzero value -> binary_out=0000 and binary_valid=0 immediately, with no clock edge. Release with gray_valid=0 -> both outputs stay 0.
- Exhaustive sweep, WIDTH=4: drive gray_in = 0000 through 1111 with gray_valid=1 on consecutive cycles. Required results one cycle later:
  - 0000->0000, 0001->0001, 0010->0011, 0011->0010
  - 0100->0111, 0101->0110, 0110->0100, 0111->0101
  - 1000->1111, 1001->1110, 1010->1100, 1011->1101
  - 1100->1000, 1101->1001, 1110->1011, 1111->1010
  - binary_valid stays high for all 16 result cycles.
- Hold/valid gap: gray_in=0110 with gray_valid=1, then 3 cycles of gray_valid=0 with gray_in=1111 -> binary_out=0100 held for all 3 cycles, with binary_valid=1 then 0, 0, 0.
- Mid-stream reset: stream 0001, 0011, 0111 and pulse rst_n low between the 2nd and 3rd edges -> outputs forced to 0 at once, and the 0111 result never appears. After release, gray_in=1000 yields 1111 one cycle later.
- Parameter check: WIDTH=8 with gray_in=10000000 -> 11111111, and 11111111 -> 10101010. WIDTH=1 with gray_in=1 -> 1.
- Random check: 1000 random gray_in/gray_valid cycles at WIDTH=16, compared against a reference model of b[i] = XOR of g[WIDTH-1:i] with 1-cycle delay. Also verify, for each result, that binary_out XOR (binary_out>>1) equals the gray_in that produced it (round-trip property).

Source files
------------

// File: rtl/gray_to_binary.sv
// Reflected Gray code to natural binary converter with a registered result and valid flag.
// Latency: 1 clock from an accepted gray_valid to binary_out/binary_valid.
// No backpressure: every valid input is accepted, one word per clock.
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    output logic [WIDTH-1:0] binary_out,
    output logic             binary_valid
);

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] bin_q;
    logic             vld_q;

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_conv
        assign bin_d[i] = ^gray_in[WIDTH-1:i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= gray_valid;
            if (gray_valid) begin
                bin_q <= bin_d;
            end
        end
    end

    assign binary_out   = bin_q;
    assign binary_valid = vld_q;

endmodule

// File: tb/tb_gray_to_binary.sv
// Directed and random checks of gray_to_binary at WIDTH = 4, 8, 1 and 16.
module tb_gray_to_binary;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  g4;  logic v4;  logic [3:0]  b4;  logic bv4;
    logic [7:0]  g8;  logic v8;  logic [7:0]  b8;  logic bv8;
    logic [0:0]  g1;  logic v1;  logic [0:0]  b1;  logic bv1;
    logic [15:0] g16; logic v16; logic [15:0] b16; logic bv16;

    gray_to_binary #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .gray_in(g4), .gray_valid(v4),
        .binary_out(b4), .binary_valid(bv4));
    gray_to_binary #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .gray_in(g8), .gray_valid(v8),
        .binary_out(b8), .binary_valid(bv8));
    gray_to_binary #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .gray_in(g1), .gray_valid(v1),
        .binary_out(b1), .binary_valid(bv1));
    gray_to_binary #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .gray_in(g16), .gray_valid(v16),
        .binary_out(b16), .binary_valid(bv16));

    int errors = 0;
    int checks = 0;

    logic [3:0]  q4[$];
    logic [15:0] q16_exp[$];
    logic [15:0] q16_gray[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref16(input logic [15:0] g);
        logic [15:0] b;
        for (int i = 0; i < 16; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    initial begin
        logic [3:0]  tbl [16];
        logic [15:0] exp16;
        logic [15:0] gin16;
        logic [15:0] last16;
        tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};

        rst_n = 1'b0;
        g4 = '0; v4 = 1'b0; g8 = '0; v8 = 1'b0;
        g1 = '0; v1 = 1'b0; g16 = '0; v16 = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Load a nonzero value, then reset asynchronously between edges.
        g4 = 4'hF; v4 = 1'b1;
        step();
        chk("preload_b4", 64'(b4), 64'hA);
        v4 = 1'b0; g4 = 'x;
        rst_n = 1'b0;
        #2;
        chk("async_rst_b4", 64'(b4), 64'h0);
        chk("async_rst_bv4", 64'(bv4), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_b4", 64'(b4), 64'h0);
        chk("post_rst_bv4", 64'(bv4), 64'h0);

        // Exhaustive 4-bit sweep, back to back.
        for (int i = 0; i < 16; i++) begin
            g4 = 4'(i); v4 = 1'b1;
            q4.push_back(tbl[i]);
            step();
            chk($sformatf("sweep_vld_%0d", i), 64'(bv4), 64'h1);
            if (q4.size() > 0) chk($sformatf("sweep_%0d", i), 64'(b4), 64'(q4.pop_front()));
        end
        v4 = 1'b0;

        // Hold across a valid gap.
        g4 = 4'h6; v4 = 1'b1;
        step();
        chk("gap_b4_0", 64'(b4), 64'h4);
        chk("gap_bv4_0", 64'(bv4), 64'h1);
        g4 = 4'hF; v4 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("gap_b4_%0d", i), 64'(b4), 64'h4);
            chk($sformatf("gap_bv4_%0d", i), 64'(bv4), 64'h0);
        end

        // Mid-stream reset: 0111 is presented but must never emerge.
        g4 = 4'h1; v4 = 1'b1;
        step();
        chk("ms_b4_1", 64'(b4), 64'h1);
        g4 = 4'h3;
        step();
        chk("ms_b4_2", 64'(b4), 64'h2);
        g4 = 4'h7;
        rst_n = 1'b0;
        #2;
        chk("ms_rst_b4", 64'(b4), 64'h0);
        chk("ms_rst_bv4", 64'(bv4), 64'h0);
        step();
        chk("ms_held_b4", 64'(b4), 64'h0);
        chk("ms_held_bv4", 64'(bv4), 64'h0);
        rst_n = 1'b1;
        g4 = 4'h8;
        step();
        chk("ms_after_b4", 64'(b4), 64'hF);
        chk("ms_after_bv4", 64'(bv4), 64'h1);
        v4 = 1'b0;
        step();
        chk("ms_end_b4", 64'(b4), 64'hF);
        chk("ms_end_bv4", 64'(bv4), 64'h0);

        // Other widths.
        g8 = 8'h80; v8 = 1'b1;
        step();
        chk("w8_80", 64'(b8), 64'hFF);
        chk("w8_80_vld", 64'(bv8), 64'h1);
        g8 = 8'hFF;
        step();
        chk("w8_ff", 64'(b8), 64'hAA);
        v8 = 1'b0;
        g1 = 1'b1; v1 = 1'b1;
        step();
        chk("w1_1", 64'(b1), 64'h1);
        chk("w1_1_vld", 64'(bv1), 64'h1);
        g1 = 1'b0;
        step();
        chk("w1_0", 64'(b1), 64'h0);
        v1 = 1'b0;

        // Random 16-bit traffic with scoreboard and round-trip property.
        last16 = 16'h0;
        for (int n = 0; n < 1000; n++) begin
            v16 = ($urandom_range(0, 9) < 7);
            g16 = 16'($urandom);
            if (v16) begin
                q16_exp.push_back(ref16(g16));
                q16_gray.push_back(g16);
            end
            step();
            if (q16_exp.size() > 0) begin
                exp16 = q16_exp.pop_front();
                gin16 = q16_gray.pop_front();
                chk("rnd_vld", 64'(bv16), 64'h1);
                chk("rnd_bin", 64'(b16), 64'(exp16));
                chk("rnd_roundtrip", 64'(b16 ^ (b16 >> 1)), 64'(gin16));
                last16 = exp16;
            end else begin
                chk("rnd_idle_vld", 64'(bv16), 64'h0);
                chk("rnd_hold", 64'(b16), 64'(last16));
            end
        end
        v16 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
